// File: rtl/audio_dac_serializer_if.sv
// Stereo sample write handshake between the tone/mix logic and the DAC serializer.
// The producer drives a pair plus write strobe; the sink reports whether it can accept.
interface audio_dac_serializer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] left_channel_audio_out;
    logic [DATA_WIDTH-1:0] right_channel_audio_out;
    logic                  write_audio_out;
    logic                  audio_out_allowed;

    modport master (
        output left_channel_audio_out,
        output right_channel_audio_out,
        output write_audio_out,
        input  audio_out_allowed
    );

    modport slave (
        input  left_channel_audio_out,
        input  right_channel_audio_out,
        input  write_audio_out,
        output audio_out_allowed
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Buffers stereo pairs in a small FIFO and shifts them MSB-first onto the WM8731 DAC
// pin in I2S format, timed by the codec-mastered BCLK/LRCK (synchronized into CLOCK_50).
module audio_dac_serializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  clear_audio_out_memory,
    audio_dac_serializer_if.slave aud_if,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  underrun
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] WORD_BITS = BIT_W'(DATA_WIDTH);

    typedef enum logic {StWaitSync, StFramed} sync_state_e;

    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0] head;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    allowed_q, allowed_d;
    // [0],[1] form the synchronizer, [2] holds the previous synchronized value
    logic [2:0]              bclk_sync_q, lr_sync_q;
    logic [DATA_WIDTH-1:0]   hold_r_q, hold_r_d, shreg_q, shreg_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    dacdat_q, dacdat_d, underrun_q, underrun_d;
    sync_state_e             state_q, state_d;
    logic                    bclk_fall, lr_fall, lr_rise, push, pop;

    assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
    assign lr_fall   = lr_sync_q[2] & ~lr_sync_q[1];
    assign lr_rise   = ~lr_sync_q[2] & lr_sync_q[1];
    assign push      = aud_if.write_audio_out & allowed_q & ~clear_audio_out_memory;
    assign pop       = lr_fall & (count_q != '0) & ~clear_audio_out_memory;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_r_d   = hold_r_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        dacdat_d   = dacdat_q;
        underrun_d = 1'b0;
        state_d    = state_q;

        if (clear_audio_out_memory) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end

        // An LR edge wins over a coincident BCLK fall: it is the I2S delay slot.
        if (lr_fall) begin
            state_d    = StFramed;
            // A frame start that cannot pop (empty or being cleared) sends silence.
            underrun_d = ~pop;
            shreg_d    = pop ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            hold_r_d   = pop ? head[DATA_WIDTH-1:0] : '0;
            bit_cnt_d  = '0;
            dacdat_d   = 1'b0;
        end else if (lr_rise && state_q == StFramed) begin
            shreg_d   = hold_r_q;
            bit_cnt_d = '0;
            dacdat_d  = 1'b0;
        end else if (bclk_fall && state_q == StFramed) begin
            if (bit_cnt_q < WORD_BITS) begin
                dacdat_d  = shreg_q[DATA_WIDTH-1];
                shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else begin
                dacdat_d = 1'b0;
            end
        end

        allowed_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            allowed_q   <= 1'b1;
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            hold_r_q    <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            dacdat_q    <= 1'b0;
            underrun_q  <= 1'b0;
            state_q     <= StWaitSync;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            allowed_q   <= allowed_d;
            bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
            lr_sync_q   <= {lr_sync_q[1:0], AUD_DACLRCK};
            hold_r_q    <= hold_r_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            dacdat_q    <= dacdat_d;
            underrun_q  <= underrun_d;
            state_q     <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {aud_if.left_channel_audio_out, aud_if.right_channel_audio_out};
        end
    end

    assign aud_if.audio_out_allowed = allowed_q;
    assign AUD_DACDAT               = dacdat_q;
    assign fifo_count               = count_q;
    assign underrun                 = underrun_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench: an I2S codec model drives BCLK/LRCK and decodes DACDAT per half-frame,
// compared against a queue-based FIFO model and the I2S slot rules.
module tb_audio_dac_serializer;
    localparam int unsigned DW = 32;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       clear_audio_out_memory = 1'b0;
    logic       AUD_BCLK = 1'b1;
    logic       AUD_DACLRCK = 1'b1;
    logic       AUD_DACDAT;
    logic [3:0] fifo_count;
    logic       underrun;

    int n_tests = 0;
    int n_fail  = 0;

    audio_dac_serializer_if #(.DATA_WIDTH(DW)) aud_if ();

    audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .CNT_W(4)) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .clear_audio_out_memory (clear_audio_out_memory),
        .aud_if                 (aud_if),
        .AUD_BCLK               (AUD_BCLK),
        .AUD_DACLRCK            (AUD_DACLRCK),
        .AUD_DACDAT             (AUD_DACDAT),
        .fifo_count             (fifo_count),
        .underrun               (underrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Codec model: BCLK = CLOCK_50/16, LRCK toggles on a BCLK fall every half_slots bits,
    // DACDAT captured on BCLK rise; each complete half-frame is queued as {lrck, slots}.
    bit          codec_run = 1'b0;
    bit          run_q = 1'b0;
    int          half_slots = 36;
    int          div = 0, slot = 0, rx_n = 0, rx_rd = 0;
    logic [63:0] rx_vec = '0;
    logic [64:0] rx_q[$];

    always @(negedge CLOCK_50) begin
        if (codec_run && !run_q) begin
            AUD_BCLK = 1'b1; AUD_DACLRCK = 1'b1;
            div = 8; slot = half_slots - 1; rx_n = 0; rx_vec = '0;
        end else if (codec_run) begin
            div = (div + 1) % 16;
            if (div == 8) begin
                AUD_BCLK = 1'b1;
                rx_vec = {rx_vec[62:0], AUD_DACDAT};
                rx_n++;
            end else if (div == 0) begin
                AUD_BCLK = 1'b0;
                slot++;
                if (slot == half_slots) begin
                    slot = 0;
                    if (rx_n == half_slots) rx_q.push_back({AUD_DACLRCK, rx_vec});
                    rx_n = 0; rx_vec = '0;
                    AUD_DACLRCK = ~AUD_DACLRCK;
                end
            end
        end
        run_q = codec_run;
    end

    int   ur_cycles = 0, ur_long = 0;
    logic ur_prev = 1'b0;
    always @(negedge CLOCK_50) begin
        if (underrun) ur_cycles++;
        if (underrun && ur_prev) ur_long++;
        ur_prev = underrun;
    end

    logic [63:0] model_q[$];

    // Slot 0 is the delay slot, slots 1..DW carry the word MSB-first, the rest are zero.
    function automatic logic [63:0] expect_half(input logic [31:0] word, input int n);
        logic [63:0] v;
        logic        b;
        v = '0;
        for (int k = 0; k < n; k++) begin
            b = (k >= 1 && k <= DW) ? word[DW-k] : 1'b0;
            v = {v[62:0], b};
        end
        return v;
    endfunction

    function automatic logic [63:0] model_pop();
        if (model_q.size() > 0) return model_q.pop_front();
        return '0;
    endfunction

    task automatic do_reset();
        codec_run = 1'b0;
        clear_audio_out_memory = 1'b0;
        aud_if.write_audio_out = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        model_q.delete();
        rx_rd = rx_q.size();
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        aud_if.left_channel_audio_out  = l;
        aud_if.right_channel_audio_out = r;
        aud_if.write_audio_out = 1'b1;
        @(negedge CLOCK_50);
        aud_if.write_audio_out = 1'b0;
    endtask

    // Returns at the first CLOCK_50 rise that sees the LRCK pin low after high.
    task automatic wait_lr_fall(output bit ok);
        logic prev;
        ok = 1'b0;
        @(posedge CLOCK_50);
        prev = AUD_DACLRCK;
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLOCK_50);
            if (prev && !AUD_DACLRCK) begin ok = 1'b1; break; end
            prev = AUD_DACLRCK;
        end
    endtask

    task automatic wait_halves(input int n, output bit ok);
        int budget;
        budget = n * 800 + 2000;
        for (int i = 0; i < budget && (rx_q.size() - rx_rd) < n; i++) @(negedge CLOCK_50);
        ok = ((rx_q.size() - rx_rd) >= n);
    endtask

    task automatic get_half(output logic lr, output logic [63:0] vec);
        if (rx_rd < rx_q.size()) begin
            {lr, vec} = rx_q[rx_rd];
            rx_rd++;
        end else begin
            lr = 1'b0; vec = '0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count);
        end
        n_tests++;
        if (aud_if.audio_out_allowed !== 1'b1) begin
            n_fail++; $display("FAIL reset_allowed: got %b want 1", aud_if.audio_out_allowed);
        end
        n_tests++;
        if (AUD_DACDAT !== 1'b0) begin
            n_fail++; $display("FAIL reset_dacdat: got %b want 0", AUD_DACDAT);
        end
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun);
        end
    endtask

    task automatic test_basic();
        bit          ok;
        int          base, base_long;
        logic        lr;
        logic [63:0] vec, exp_v;
        logic [31:0] words [4];
        do_reset();
        half_slots = 32;
        base = ur_cycles; base_long = ur_long;
        words[0] = 32'hA5A5_0001; words[1] = 32'h0000_FFFF; words[2] = '0; words[3] = '0;
        push_pair(words[0], words[1]);
        @(negedge CLOCK_50);
        n_tests++;
        if (fifo_count !== 4'd1) begin
            n_fail++; $display("FAIL basic_count_after_write: got %0d want 1", fifo_count);
        end
        codec_run = 1'b1;
        wait_lr_fall(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL basic_lr_timeout: got no LRCK fall want one"); return;
        end
        repeat (2) @(negedge CLOCK_50);
        n_tests++;
        if (fifo_count !== 4'd1) begin
            n_fail++; $display("FAIL basic_count_before_pop: got %0d want 1", fifo_count);
        end
        @(negedge CLOCK_50);
        n_tests++;
        if (fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL basic_count_after_pop: got %0d want 0", fifo_count);
        end
        wait_halves(4, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL basic_frame_timeout: got %0d halves want 4", rx_q.size() - rx_rd);
            codec_run = 1'b0; return;
        end
        n_tests++;
        if (ur_cycles - base !== 1 || ur_long !== base_long) begin
            n_fail++; $display("FAIL basic_underrun_pulse: got %0d cycles (%0d long) want 1 (0)",
                               ur_cycles - base, ur_long - base_long);
        end
        codec_run = 1'b0;
        for (int h = 0; h < 4; h++) begin
            get_half(lr, vec);
            exp_v = expect_half(words[h], half_slots);
            n_tests++;
            if (lr !== h[0] || vec !== exp_v) begin
                n_fail++; $display("FAIL basic_half%0d: got lr=%b %h want lr=%b %h", h, lr, vec,
                                   h[0], exp_v);
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] l, r;
        do_reset();
        half_slots = 36;
        for (int i = 0; i < 9; i++) begin
            l = $urandom; r = $urandom;
            push_pair(l, r);
            if (model_q.size() < 8) model_q.push_back({l, r});
            if (i == 7) begin
                n_tests++;
                if (fifo_count !== 4'd8 || aud_if.audio_out_allowed !== 1'b0) begin
                    n_fail++; $display("FAIL full_after_8: got count=%0d allowed=%b want 8 0",
                                       fifo_count, aud_if.audio_out_allowed);
                end
            end
        end
        n_tests++;
        if (fifo_count !== 4'd8 || aud_if.audio_out_allowed !== 1'b0) begin
            n_fail++; $display("FAIL full_after_9: got count=%0d allowed=%b want 8 0",
                               fifo_count, aud_if.audio_out_allowed);
        end
    endtask

    // Continues from test_full: the FIFO holds 8 pairs and the codec is idle.
    task automatic test_simultaneous();
        bit          ok;
        int          base;
        logic        lr;
        logic [63:0] vec, pair, exp_v;
        base = ur_cycles;
        codec_run = 1'b1;
        wait_lr_fall(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL simul_lr_timeout: got no LRCK fall want one"); return;
        end
        repeat (2) @(negedge CLOCK_50);
        n_tests++;
        if (fifo_count !== 4'd8 || aud_if.audio_out_allowed !== 1'b0) begin
            n_fail++; $display("FAIL simul_before: got count=%0d allowed=%b want 8 0",
                               fifo_count, aud_if.audio_out_allowed);
        end
        push_pair(32'hDEAD_BEEF, 32'hFEED_F00D);
        n_tests++;
        if (fifo_count !== 4'd7 || aud_if.audio_out_allowed !== 1'b1) begin
            n_fail++; $display("FAIL simul_after: got count=%0d allowed=%b want 7 1",
                               fifo_count, aud_if.audio_out_allowed);
        end
        wait_halves(18, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL simul_frame_timeout: got %0d halves want 18", rx_q.size() - rx_rd);
            codec_run = 1'b0; return;
        end
        n_tests++;
        if (ur_cycles - base !== 1) begin
            n_fail++; $display("FAIL simul_underrun: got %0d want 1", ur_cycles - base);
        end
        codec_run = 1'b0;
        for (int f = 0; f < 9; f++) begin
            pair = model_pop();
            get_half(lr, vec);
            exp_v = expect_half(pair[63:32], half_slots);
            n_tests++;
            if (lr !== 1'b0 || vec !== exp_v) begin
                n_fail++; $display("FAIL simul_left%0d: got lr=%b %h want lr=0 %h", f, lr, vec, exp_v);
            end
            get_half(lr, vec);
            exp_v = expect_half(pair[31:0], half_slots);
            n_tests++;
            if (lr !== 1'b1 || vec !== exp_v) begin
                n_fail++; $display("FAIL simul_right%0d: got lr=%b %h want lr=1 %h", f, lr, vec, exp_v);
            end
        end
    endtask

    task automatic test_clear();
        bit          ok;
        int          base;
        logic        lr;
        logic [63:0] vec, exp_v, first;
        logic [31:0] l, r;
        logic [31:0] words [4];
        do_reset();
        half_slots = 36;
        base = ur_cycles;
        for (int i = 0; i < 6; i++) begin
            l = $urandom; r = $urandom;
            push_pair(l, r);
            model_q.push_back({l, r});
        end
        first = model_pop();
        codec_run = 1'b1;
        wait_lr_fall(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL clear_lr_timeout: got no LRCK fall want one"); return;
        end
        repeat (160) @(negedge CLOCK_50);
        n_tests++;
        if (fifo_count !== 4'd5) begin
            n_fail++; $display("FAIL clear_before: got %0d want 5", fifo_count);
        end
        clear_audio_out_memory = 1'b1;
        @(negedge CLOCK_50);
        clear_audio_out_memory = 1'b0;
        n_tests++;
        if (fifo_count !== 4'd0 || aud_if.audio_out_allowed !== 1'b1) begin
            n_fail++; $display("FAIL clear_after: got count=%0d allowed=%b want 0 1",
                               fifo_count, aud_if.audio_out_allowed);
        end
        wait_halves(4, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL clear_frame_timeout: got %0d halves want 4", rx_q.size() - rx_rd);
            codec_run = 1'b0; return;
        end
        n_tests++;
        if (ur_cycles - base !== 1) begin
            n_fail++; $display("FAIL clear_underrun: got %0d want 1", ur_cycles - base);
        end
        codec_run = 1'b0;
        words[0] = first[63:32]; words[1] = first[31:0]; words[2] = '0; words[3] = '0;
        for (int h = 0; h < 4; h++) begin
            get_half(lr, vec);
            exp_v = expect_half(words[h], half_slots);
            n_tests++;
            if (lr !== h[0] || vec !== exp_v) begin
                n_fail++; $display("FAIL clear_half%0d: got lr=%b %h want lr=%b %h", h, lr, vec,
                                   h[0], exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit          ok;
        int          base;
        logic        lr;
        logic [63:0] vec, exp_v;
        logic [31:0] bl, br;
        logic [31:0] words [3];
        do_reset();
        half_slots = 36;
        push_pair($urandom, $urandom);
        push_pair(32'h1234_5678, 32'h9ABC_DEF0);
        codec_run = 1'b1;
        wait_lr_fall(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rmf_lr_timeout: got no LRCK fall want one"); return;
        end
        repeat (11 * 16 + 4) @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        base = ur_cycles;
        n_tests++;
        if (fifo_count !== 4'd0 || AUD_DACDAT !== 1'b0 || aud_if.audio_out_allowed !== 1'b1) begin
            n_fail++; $display("FAIL rmf_after_reset: got count=%0d dacdat=%b allowed=%b want 0 0 1",
                               fifo_count, AUD_DACDAT, aud_if.audio_out_allowed);
        end
        for (int i = 0; i < 1000 && !AUD_DACLRCK; i++) @(posedge CLOCK_50);
        rx_rd = rx_q.size();
        @(negedge CLOCK_50);
        bl = $urandom; br = $urandom;
        push_pair(bl, br);
        wait_halves(3, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rmf_frame_timeout: got %0d halves want 3", rx_q.size() - rx_rd);
            codec_run = 1'b0; return;
        end
        n_tests++;
        if (ur_cycles !== base) begin
            n_fail++; $display("FAIL rmf_underrun: got %0d want 0", ur_cycles - base);
        end
        codec_run = 1'b0;
        words[0] = '0; words[1] = bl; words[2] = br;
        for (int h = 0; h < 3; h++) begin
            get_half(lr, vec);
            exp_v = expect_half(words[h], half_slots);
            n_tests++;
            if (lr !== ~h[0] || vec !== exp_v) begin
                n_fail++; $display("FAIL rmf_half%0d: got lr=%b %h want lr=%b %h", h, lr, vec,
                                   ~h[0], exp_v);
            end
        end
    endtask

    task automatic test_random_stream();
        bit          ok;
        int          base, k;
        logic        lr;
        logic [63:0] vec, pair, exp_v;
        logic [31:0] l, r;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            half_slots = $urandom_range(24, 40);
            k = $urandom_range(1, 6);
            base = ur_cycles;
            for (int i = 0; i < k; i++) begin
                l = $urandom; r = $urandom;
                push_pair(l, r);
                model_q.push_back({l, r});
            end
            n_tests++;
            if (fifo_count !== 4'(k)) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", round, fifo_count, k);
            end
            codec_run = 1'b1;
            wait_halves(2 * (k + 1), ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL rand%0d_timeout: got %0d halves want %0d", round,
                                   rx_q.size() - rx_rd, 2 * (k + 1));
                codec_run = 1'b0; return;
            end
            n_tests++;
            if (ur_cycles - base !== 1) begin
                n_fail++; $display("FAIL rand%0d_underrun: got %0d want 1", round, ur_cycles - base);
            end
            codec_run = 1'b0;
            for (int f = 0; f <= k; f++) begin
                pair = model_pop();
                get_half(lr, vec);
                exp_v = expect_half(pair[63:32], half_slots);
                n_tests++;
                if (lr !== 1'b0 || vec !== exp_v) begin
                    n_fail++; $display("FAIL rand%0d_left%0d: got lr=%b %h want lr=0 %h", round, f,
                                       lr, vec, exp_v);
                end
                get_half(lr, vec);
                exp_v = expect_half(pair[31:0], half_slots);
                n_tests++;
                if (lr !== 1'b1 || vec !== exp_v) begin
                    n_fail++; $display("FAIL rand%0d_right%0d: got lr=%b %h want lr=1 %h", round, f,
                                       lr, vec, exp_v);
                end
            end
        end
    endtask

    initial begin
        aud_if.left_channel_audio_out  = '0;
        aud_if.right_channel_audio_out = '0;
        aud_if.write_audio_out         = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_simultaneous();
        test_clear();
        test_reset_mid_frame();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
